// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Round-robin front end that lets two requesters share one external
// combinational ALU. An accepted request is held in an issue-stage register
// that drives the ALU directly. The ALU result is captured one cycle later
// in a response-stage register, and a one-cycle response strobe is raised
// toward the requester that issued the operation.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   hold                         stall; suppresses new grants only
//   req_valid_x / req_ready_x    request handshake for requester x (0/1)
//   req_a_x, req_b_x, req_op_x   operands and op code of requester x
//   alu_a, alu_b, alu_op         operands and op code to the shared ALU
//   alu_result, alu_zero         shared ALU outputs
//   rsp_valid_x                  one-cycle response strobe for requester x
//   rsp_result, rsp_zero         response data; zero while no strobe is high
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,

    input  logic         req_valid_0,
    input  logic [N-1:0] req_a_0,
    input  logic [N-1:0] req_b_0,
    input  logic [3:0]   req_op_0,
    output logic         req_ready_0,

    input  logic         req_valid_1,
    input  logic [N-1:0] req_a_1,
    input  logic [N-1:0] req_b_1,
    input  logic [3:0]   req_op_1,
    output logic         req_ready_1,

    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,

    output logic         rsp_valid_0,
    output logic         rsp_valid_1,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero
);

    // How the ALU outputs of an op are forwarded in the response.
    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,  // op 0000 / 1111: respond with all zeros
        CLS_ARITH = 2'd1,  // op 0001-1000: forward alu_result
        CLS_CMP   = 2'd2   // op 1001-1110: forward alu_zero only
    } op_class_t;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    // ptr names the requester that wins the next contention (0 or 1).
    logic ptr;
    logic grant_0;
    logic grant_1;
    logic fire;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (!hold) begin
            if (req_valid_0 && (!req_valid_1 || !ptr)) begin
                grant_0 = 1'b1;
            end else if (req_valid_1) begin
                grant_1 = 1'b1;
            end
        end
    end

    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;
    assign fire        = grant_0 | grant_1;

    // -----------------------------------------------------------------------
    // Issue stage
    // -----------------------------------------------------------------------
    logic         iss_valid;
    logic         iss_id;
    logic [N-1:0] iss_a;
    logic [N-1:0] iss_b;
    logic [3:0]   iss_op;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            iss_valid <= 1'b0;
            iss_id    <= 1'b0;
            iss_a     <= '0;
            iss_b     <= '0;
            iss_op    <= '0;
        end else begin
            iss_valid <= fire;
            iss_id    <= grant_1;
            // An empty issue stage holds zeros so the ALU sees a quiet bus.
            if (fire) begin
                iss_a  <= grant_1 ? req_a_1  : req_a_0;
                iss_b  <= grant_1 ? req_b_1  : req_b_0;
                iss_op <= grant_1 ? req_op_1 : req_op_0;
                // The loser of this transfer wins the next contention.
                ptr    <= grant_0;
            end else begin
                iss_a  <= '0;
                iss_b  <= '0;
                iss_op <= '0;
            end
        end
    end

    assign alu_a  = iss_a;
    assign alu_b  = iss_b;
    assign alu_op = iss_op;

    // -----------------------------------------------------------------------
    // Response stage
    // -----------------------------------------------------------------------
    op_class_t    iss_class;
    logic [N-1:0] nxt_result;
    logic         nxt_zero;

    always_comb begin
        iss_class = CLS_NONE;
        if (iss_op >= 4'd1 && iss_op <= 4'd8) begin
            iss_class = CLS_ARITH;
        end else if (iss_op >= 4'd9 && iss_op <= 4'd14) begin
            iss_class = CLS_CMP;
        end
    end

    always_comb begin
        nxt_result = '0;
        nxt_zero   = 1'b0;
        if (iss_valid) begin
            case (iss_class)
                CLS_ARITH: nxt_result = alu_result;
                CLS_CMP:   nxt_zero   = alu_zero;
                default:   ;
            endcase
        end
    end

    logic rsp_valid_q;
    logic rsp_id_q;

    // Loading zeros whenever the issue stage is empty keeps the response
    // data at zero between strobes and prevents carry-over between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
        end else begin
            rsp_valid_q <= iss_valid;
            rsp_id_q    <= iss_id;
            rsp_result  <= nxt_result;
            rsp_zero    <= nxt_zero;
        end
    end

    assign rsp_valid_0 = rsp_valid_q & ~rsp_id_q;
    assign rsp_valid_1 = rsp_valid_q &  rsp_id_q;

endmodule
